decode_scan: RTL and testbench

Parametrised registered one-hot decoder with an auto-scan mode. In direct mode it decodes an SEL_W-bit select into a 2**SEL_W-bit one-hot output, registered on the clock. In scan mode it steps an internal index through every output position, holding each for DWELL cycles, and wraps. It drives row, digit and chip-select lines in display and bus-select paths. It replaces the combinational 3-to-8 decoder in new designs.

---
 rtl/decode_pkg.sv | 13 +
 rtl/decode_scan_if.sv | 23 ++
 rtl/decode_dwell_cnt.sv | 29 ++
 rtl/decode_scan.sv | 86 ++++++++
 tb/tb_decode_scan.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared types for the decode_scan one-hot decoder: FSM state encoding and mode constants.
package decode_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DIRECT,
      SCAN
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decode_scan_if.sv
// Control and output bundle of decode_scan; master drives select/mode, slave returns the decoded lines.
interface decode_scan_if #(
   parameter int SEL_W = 3
) ();
   localparam int OUT_W = 2 ** SEL_W;

   logic             enable;
   logic             mode;
   logic [SEL_W-1:0] data_in;
   logic [OUT_W-1:0] data_out;
   logic [SEL_W-1:0] index;
   logic             wrap;

   modport master (
      output enable, mode, data_in,
      input  data_out, index, wrap
   );

   modport slave (
      input  enable, mode, data_in,
      output data_out, index, wrap
   );
endinterface

// File: rtl/decode_dwell_cnt.sv
// Dwell timer for scan mode: down-counter reloaded with DWELL-1, terminal count at zero.
module decode_dwell_cnt #(
   parameter int DWELL = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic load,
   output logic tc
);
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_W'(DWELL - 1);
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/decode_scan.sv
// Registered one-hot decoder with auto-scan; DECODE_SCAN_ACTIVE_LOW_EN inverts data_out.
//
// state  | meaning
// IDLE   | enable low: lines inactive, index held, dwell timer cleared
// DIRECT | data_out/index follow data_in one cycle later
// SCAN   | index steps 0..OUT_W-1, DWELL cycles per position, wrap pulse on return to 0
module decode_scan
   import decode_pkg::*;
#(
   parameter int SEL_W = 3,
   parameter int DWELL = 50
) (
   input  logic          clk,
   input  logic          rst_n,
   decode_scan_if.slave  bus
);
   localparam int OUT_W = 2 ** SEL_W;

   state_t           state;
   logic [OUT_W-1:0] onehot;
   logic [SEL_W-1:0] index_q;
   logic             wrap_q;
   logic             scan_sel;
   logic             cnt_clear;
   logic             cnt_load;
   logic             tc;

   assign scan_sel = bus.enable && (bus.mode == MODE_SCAN);

   // Entering scan, or finishing a position, reloads the timer; anything but scan parks it.
   assign cnt_clear = !scan_sel;
   assign cnt_load  = scan_sel && ((state != SCAN) || tc);

   decode_dwell_cnt #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (cnt_clear),
      .load  (cnt_load),
      .tc    (tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         onehot  <= '0;
         index_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         if (!bus.enable) begin
            state  <= IDLE;
            onehot <= '0;
         end else if (bus.mode == MODE_DIRECT) begin
            state   <= DIRECT;
            onehot  <= OUT_W'(1) << bus.data_in;
            index_q <= bus.data_in;
         end else begin
            state <= SCAN;
            if (state != SCAN) begin
               index_q <= '0;
               onehot  <= OUT_W'(1);
            end else if (tc) begin
               if (&index_q) begin
                  index_q <= '0;
                  onehot  <= OUT_W'(1);
                  wrap_q  <= 1'b1;
               end else begin
                  index_q <= index_q + 1'b1;
                  onehot  <= onehot << 1;
               end
            end
         end
      end
   end

`ifdef DECODE_SCAN_ACTIVE_LOW_EN
   assign bus.data_out = ~onehot;
`else
   assign bus.data_out = onehot;
`endif
   assign bus.index = index_q;
   assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_decode_scan.sv
// Self-checking bench for decode_scan (SEL_W=3, DWELL=4): vector table, directed corners, random vs model.
module tb_decode_scan;
   localparam int SEL_W  = 3;
   localparam int DWELL  = 4;
   localparam int OUT_W  = 2 ** SEL_W;
   localparam int PERIOD = OUT_W * DWELL;
`ifdef DECODE_SCAN_ACTIVE_LOW_EN
   localparam logic [OUT_W-1:0] INV = '1;
`else
   localparam logic [OUT_W-1:0] INV = '0;
`endif

   logic clk;
   logic rst_n;

   decode_scan_if #(.SEL_W(SEL_W)) bus ();

   decode_scan #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: position derived from cycles elapsed since scan entry
   logic [OUT_W-1:0] m_out;
   int               m_idx;
   logic             m_wrap;
   bit               m_in_scan;
   int               m_k;

   typedef struct {
      logic       en;
      logic       md;
      int         din;
      logic [7:0] exp_out;
      int         exp_idx;
      logic       exp_wrap;
   } vec_t;

   vec_t vecs[10];

   function automatic void chk(string name, longint act, longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_out = '0; m_idx = 0; m_wrap = 0; m_in_scan = 0; m_k = 0;
   endfunction

   function automatic void model_step(logic en, logic md, int din);
      m_wrap = 0;
      if (!en) begin
         m_out = '0;
         m_in_scan = 0;
      end else if (!md) begin
         m_idx = din;
         m_out = OUT_W'(1) << din;
         m_in_scan = 0;
      end else begin
         if (!m_in_scan) m_k = 0;
         else m_k++;
         m_in_scan = 1;
         m_idx  = (m_k / DWELL) % OUT_W;
         m_out  = OUT_W'(1) << m_idx;
         m_wrap = (m_k != 0) && (m_k % PERIOD == 0);
      end
   endfunction

   task automatic cycle(logic en, logic md, int din);
      bus.enable  = en;
      bus.mode    = md;
      bus.data_in = SEL_W'(din);
      @(posedge clk);
      model_step(en, md, din);
      #1;
   endtask

   task automatic chk_model(string tag);
      chk({tag, ".data_out"}, bus.data_out, m_out ^ INV);
      chk({tag, ".index"}, bus.index, m_idx);
      chk({tag, ".wrap"}, bus.wrap, m_wrap);
   endtask

   initial begin
      int wraps;
      int wrap_cycle;
      logic en, md;

      vecs[0] = '{1'b0, 1'b1, 5, 8'h00, 0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 6, 8'h00, 0, 1'b0};
      for (int i = 0; i < 8; i++)
         vecs[2+i] = '{1'b1, 1'b0, i, 8'h01 << i, i, 1'b0};

      rst_n = 1'b0;
      bus.enable = 0; bus.mode = 0; bus.data_in = '0;
      model_reset();
      #3;
      chk("reset.data_out", bus.data_out, 8'h00 ^ INV);
      chk("reset.index", bus.index, 0);
      chk("reset.wrap", bus.wrap, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int c = 0; c < 10; c++) begin
         cycle(1'b0, 1'b1, 3);
         chk("idle_mode1.data_out", bus.data_out, 8'h00 ^ INV);
      end

      foreach (vecs[i]) begin
         cycle(vecs[i].en, vecs[i].md, vecs[i].din);
         chk("vec.data_out", bus.data_out, vecs[i].exp_out ^ INV);
         chk("vec.index", bus.index, vecs[i].exp_idx);
         chk("vec.wrap", bus.wrap, vecs[i].exp_wrap);
      end

      // 40-cycle scan: 4 cycles per position, single wrap on cycle 33
      wraps = 0; wrap_cycle = -1;
      for (int c = 1; c <= 40; c++) begin
         cycle(1'b1, 1'b1, 7);
         chk("scan40.data_out", bus.data_out, (8'h01 << (((c - 1) / 4) % 8)) ^ INV);
         chk("scan40.index", bus.index, ((c - 1) / 4) % 8);
         if (bus.wrap) begin wraps++; wrap_cycle = c; end
      end
      chk("scan40.wrap_count", wraps, 1);
      chk("scan40.wrap_cycle", wrap_cycle, 33);

      // mid-scan switch to direct at index 5, then back to scan
      cycle(1'b0, 1'b1, 0);
      for (int c = 0; c < 21; c++) cycle(1'b1, 1'b1, 0);
      chk("pre_switch.index", bus.index, 5);
      cycle(1'b1, 1'b0, 2);
      chk("switch_direct.data_out", bus.data_out, 8'h04 ^ INV);
      chk("switch_direct.index", bus.index, 2);
      cycle(1'b1, 1'b1, 6);
      chk("rescan.data_out", bus.data_out, 8'h01 ^ INV);
      chk("rescan.index", bus.index, 0);
      chk("rescan.wrap", bus.wrap, 0);

      // enable drop on the wrap cycle suppresses the pulse
      for (int c = 0; c < PERIOD - 1; c++) cycle(1'b1, 1'b1, 0);
      cycle(1'b0, 1'b1, 0);
      chk("drop_at_wrap.data_out", bus.data_out, 8'h00 ^ INV);
      chk("drop_at_wrap.wrap", bus.wrap, 0);
      chk("drop_at_wrap.index", bus.index, 7);

      // asynchronous reset between edges
      for (int c = 0; c < 10; c++) cycle(1'b1, 1'b1, 0);
      chk("pre_areset.index", bus.index, 2);
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      chk("areset.data_out", bus.data_out, 8'h00 ^ INV);
      chk("areset.index", bus.index, 0);
      chk("areset.wrap", bus.wrap, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // randomized run against the model, long scan stretches to reach wraps
      en = 1; md = 1;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(99) < 4) en = ~en;
         if ($urandom_range(99) < 3) md = ~md;
         cycle(en, md, int'($urandom_range(OUT_W - 1)));
         chk_model("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
